// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the master and its peers on the bus.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: valid/ready command stream in, one in-order
// response out per command. Address phase of the next command overlaps the data
// phase of the current one; a two-cycle ERROR cancels and replays the pipelined
// address phase.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    // Address stage
    logic                  ap_valid;
    logic                  ap_write;
    logic [ADDR_WIDTH-1:0] ap_addr;
    logic [2:0]            ap_size;
    logic [DATA_WIDTH-1:0] ap_wdata;

    // Data stage
    logic                  dp_valid;
    logic                  dp_write;
    logic [DATA_WIDTH-1:0] dp_wdata;

    // Set between the two cycles of an ERROR response
    logic                  suppress;

    logic                  issue;
    logic                  accept;
    logic                  complete;
    htrans_t               htrans;

    // Phase-advance and handshake decode
    always_comb begin
        issue     = HREADY && ap_valid && !suppress;
        cmd_ready = !ap_valid || issue;
        accept    = cmd_valid && cmd_ready;
        complete  = dp_valid && HREADY;
        htrans    = (ap_valid && !suppress) ? NONSEQ : IDLE;
    end

    // Address stage: load on accept, empty on issue; fields persist so the bus
    // holds its last address/control while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_addr  <= '0;
            ap_size  <= '0;
            ap_wdata <= '0;
        end else if (accept) begin
            ap_valid <= 1'b1;
            ap_write <= cmd_write;
            ap_addr  <= cmd_addr;
            ap_size  <= cmd_size;
            ap_wdata <= cmd_wdata;
        end else if (issue) begin
            ap_valid <= 1'b0;
        end
    end

    // Data stage: advances only when the slave signals HREADY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_wdata <= '0;
        end else if (HREADY) begin
            dp_valid <= issue;
            if (issue) begin
                dp_write <= ap_write;
                dp_wdata <= ap_wdata;
            end
        end
    end

    // First ERROR cycle idles the bus for the second; any HREADY clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suppress <= 1'b0;
        end else if (HREADY) begin
            suppress <= 1'b0;
        end else if (dp_valid && (HRESP == HRESP_ERROR)) begin
            suppress <= 1'b1;
        end
    end

    // Registered response, one pulse per completed data phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= complete;
            if (complete) begin
                rsp_rdata <= dp_write ? '0 : HRDATA;
                rsp_err   <= (HRESP == HRESP_ERROR);
            end
        end
    end

    // Bus outputs straight from the stage registers
    always_comb begin
        HADDR  = ap_addr;
        HWRITE = ap_write;
        HSIZE  = ap_size;
        HTRANS = htrans;
        HBURST = HBURST_SINGLE;
        HPROT  = HPROT_DEFAULT;
        HWDATA = (dp_valid && dp_write) ? dp_wdata : '0;
        busy   = ap_valid || dp_valid || suppress;
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: behavioural slave with memory, wait states and
// error regions; a reference model predicts issue order, write data and
// responses at command acceptance; monitors compare asynchronously.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rsp_count = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues, filled at command acceptance
    logic [31:0] exp_rd[$];
    logic        exp_err[$];
    logic [31:0] iss_addr[$];
    logic        iss_write[$];
    logic [2:0]  iss_size[$];
    logic [31:0] exp_wd[$];
    int          rsp_cyc[$];
    int          smp_cyc[$];

    logic [31:0] ref_mem[int];
    logic [31:0] slv_mem[int];
    int          wait_tab[int];
    bit          rand_waits = 1'b0;

    // Slave address map: 0xE0-0xFF errors; bit 2 set there means single-cycle error
    function automatic logic is_err(input logic [31:0] a);
        return a[7:5] == 3'b111;
    endfunction
    function automatic logic is_iso(input logic [31:0] a);
        return a[2];
    endfunction
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[int'(a)] = v;
        slv_mem[int'(a)] = v;
    endtask

    // Reference model: program-order memory with error writes discarded
    task automatic model_accept(input logic w, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] d);
        iss_addr.push_back(a);
        iss_write.push_back(w);
        iss_size.push_back(s);
        exp_err.push_back(is_err(a));
        if (w) begin
            exp_wd.push_back(d);
            exp_rd.push_back(32'h0);
            if (!is_err(a)) ref_mem[int'(a)] = d;
        end else begin
            exp_rd.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a));
        end
    endtask

    // Present a command from posedge+1; returns at posedge+1 after acceptance
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, output int stalls);
        stalls = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            stalls++;
            if (stalls > 100) begin
                fail("cmd_accept_timeout");
                cmd_valid = 1'b0;
                return;
            end
        end
        model_accept(w, a, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_err.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) fail("drain_timeout");
    endtask

    // Response monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid) begin
            rsp_count++;
            rsp_cyc.push_back(cyc);
            if (exp_err.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_rd.pop_front());
                chk("rsp_err", 32'(rsp_err), 32'(exp_err.pop_front()));
            end
        end
    end

    // Behavioural slave: observes each cycle at negedge, drives at posedge+1
    logic        d_act = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_err = 1'b0;
    logic        d_iso = 1'b0;
    logic        d_stage = 1'b0;
    int          d_waits = 0;
    logic        n_ready;
    logic        n_resp;
    logic [31:0] n_rdata;

    initial begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge clk);
            n_ready = 1'b1;
            n_resp  = 1'b0;
            n_rdata = $urandom;
            if (!rst_n) begin
                d_act = 1'b0;
            end else begin
                if (d_act && HREADY) begin
                    if (d_write) begin
                        if (exp_wd.size() == 0) fail("hwdata_unexpected");
                        else chk("hwdata", HWDATA, exp_wd.pop_front());
                        if (!d_err) slv_mem[int'(d_addr)] = HWDATA;
                    end
                    d_act = 1'b0;
                end
                if (HREADY && HTRANS == 2'b10) begin
                    smp_cyc.push_back(cyc);
                    if (iss_addr.size() == 0) begin
                        fail("issue_unexpected");
                    end else begin
                        chk("issue_addr", HADDR, iss_addr.pop_front());
                        chk("issue_write", 32'(HWRITE), 32'(iss_write.pop_front()));
                        chk("issue_size", 32'(HSIZE), 32'(iss_size.pop_front()));
                    end
                    d_act   = 1'b1;
                    d_addr  = HADDR;
                    d_write = HWRITE;
                    d_err   = is_err(HADDR);
                    d_iso   = is_iso(HADDR);
                    d_stage = 1'b0;
                    if (wait_tab.exists(int'(HADDR))) d_waits = wait_tab[int'(HADDR)];
                    else d_waits = rand_waits ? int'($urandom_range(2, 0)) : 0;
                end
                if (d_act) begin
                    if (d_waits > 0) begin
                        n_ready = 1'b0;
                        d_waits--;
                    end else if (d_err && !d_iso && !d_stage) begin
                        n_ready = 1'b0;
                        n_resp  = 1'b1;
                        d_stage = 1'b1;
                    end else begin
                        n_resp = d_err;
                        if (!d_write)
                            n_rdata = slv_mem.exists(int'(d_addr)) ? slv_mem[int'(d_addr)] : dflt(d_addr);
                    end
                end
            end
            @(posedge clk);
            #1;
            HREADY = n_ready;
            HRESP  = n_resp;
            HRDATA = n_rdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot;
        int base;
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'h0);
        chk("rst_hburst", 32'(HBURST), 32'h0);
        chk("rst_hprot", 32'(HPROT), 32'h3);
        @(posedge clk);
        #1;

        preload(32'h0, 32'h11);
        preload(32'h1, 32'h22);
        preload(32'h2, 32'h33);
        preload(32'hE4, 32'h5A);

        // 1: single write, latency
        send(1'b1, 32'h4, 3'b000, 32'hA5, st);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t1_htrans", 32'(HTRANS), 32'h2);
        chk("t1_hwrite", 32'(HWRITE), 32'h1);
        chk("t1_haddr", HADDR, 32'h4);
        @(negedge clk);
        chk("t1_hwdata", HWDATA, 32'hA5);
        chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk);
        #1;
        drain();

        // 2: three back-to-back reads
        base = rsp_count;
        tot = 0;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'(i), 3'b010, 32'h0, st);
            tot += st;
        end
        cmd_valid = 1'b0;
        drain();
        chk("t2_stalls", 32'(tot), 32'h0);
        chk("t2_rsp_count", 32'(rsp_count - base), 32'h3);
        n = rsp_cyc.size();
        chk("t2_rsp_spacing", 32'(rsp_cyc[n-1] - rsp_cyc[n-3]), 32'h2);
        n = smp_cyc.size();
        chk("t2_issue_spacing", 32'(smp_cyc[n-1] - smp_cyc[n-3]), 32'h2);

        // 3: two wait states with a command pipelined behind
        base = rsp_count;
        wait_tab[32'h3] = 2;
        send(1'b0, 32'h3, 3'b000, 32'h0, st);
        send(1'b0, 32'h8, 3'b010, 32'h0, st);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_htrans_hold", 32'(HTRANS), 32'h2);
            chk("t3_haddr_hold", HADDR, 32'h8);
            if (i < 2) chk("t3_cmd_ready_wait", 32'(cmd_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        drain();
        chk("t3_rsp_count", 32'(rsp_count - base), 32'h2);

        // 4: two-cycle error on a write, pipelined read replayed
        base = rsp_count;
        send(1'b1, 32'hE0, 3'b010, 32'hDEADBEEF, st);
        send(1'b0, 32'h14, 3'b010, 32'h0, st);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t4_cmd_ready_err1", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        chk("t4_htrans_idle", 32'(HTRANS), 32'h0);
        chk("t4_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t4_replay_htrans", 32'(HTRANS), 32'h2);
        chk("t4_replay_haddr", HADDR, 32'h14);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t4_rsp_err", 32'(rsp_err), 32'h1);
        @(posedge clk);
        #1;
        drain();
        chk("t4_rsp_count", 32'(rsp_count - base), 32'h2);

        // 6: isolated single-cycle error, no bubble
        base = rsp_count;
        send(1'b0, 32'hE4, 3'b010, 32'h0, st);
        send(1'b0, 32'h20, 3'b010, 32'h0, st);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t6_htrans_next", 32'(HTRANS), 32'h2);
        chk("t6_haddr_next", HADDR, 32'h20);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        chk("t6_htrans_after", 32'(HTRANS), 32'h0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t6_rsp_rdata", rsp_rdata, 32'h5A);
        @(negedge clk);
        chk("t6_rsp2_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk);
        #1;
        drain();
        chk("t6_rsp_count", 32'(rsp_count - base), 32'h2);

        // 5: reset during a wait-stated data phase with a command in the AS
        wait_tab[32'h30] = 5;
        send(1'b0, 32'h30, 3'b010, 32'h0, st);
        send(1'b0, 32'h34, 3'b010, 32'h0, st);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_htrans", 32'(HTRANS), 32'h0);
        chk("t5_haddr", HADDR, 32'h0);
        chk("t5_hwrite", 32'(HWRITE), 32'h0);
        chk("t5_hsize", 32'(HSIZE), 32'h0);
        chk("t5_hwdata", HWDATA, 32'h0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'h1);
        exp_rd.delete();
        exp_err.delete();
        iss_addr.delete();
        iss_write.delete();
        iss_size.delete();
        exp_wd.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = rsp_count;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 32'h44, 3'b010, 32'h1234, st);
        send(1'b0, 32'h44, 3'b010, 32'h0, st);
        cmd_valid = 1'b0;
        drain();
        chk("t5_rsp_count", 32'(rsp_count - base), 32'h2);

        // Randomized traffic with random wait states and errors
        wait_tab.delete();
        rand_waits = 1'b1;
        base = rsp_count;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(1, 0)), 32'($urandom_range(255, 0)),
                 3'($urandom_range(2, 0)), $urandom, st);
            if ($urandom_range(2, 0) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(2, 1)) @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        drain();
        chk("rand_rsp_count", 32'(rsp_count - base), 32'd300);
        chk("rand_issue_left", 32'(iss_addr.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
